sigmoid_inv_approx: RTL and testbench

Piecewise-linear inverse sigmoid (logit) on IEEE-754 single-precision values. It inverts the team's 4-segment sigmoid PWL: slopes 1/4, 1/8, 1/32 with saturation at |x|=5. It feeds measured activations back into pre-activation space for the training/debug path. It is multi-cycle, shares one float adder, and uses a valid/ready handshake on both sides.

---
 rtl/sigmoid_inv_approx_pkg.sv | 51 +++++
 rtl/float_add.sv | 76 +++++++
 rtl/sigmoid_inv_approx_scale.sv | 15 +
 rtl/sigmoid_inv_approx.sv | 168 ++++++++++++++++
 tb/tb_sigmoid_inv_approx.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_inv_approx_pkg.sv
// Shared types and float32 constants for the piecewise-linear inverse sigmoid.
// Segment table inverts the 4-segment sigmoid PWL (slopes 1/4, 1/8, 1/32).
package sigmoid_inv_approx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    REFLECT,
    SUB,
    SCALE,
    DONE
  } state_e;

  localparam logic [31:0] ONE        = 32'h3F80_0000;
  localparam logic [31:0] HALF       = 32'h3F00_0000;
  localparam logic [31:0] POS5       = 32'h40A0_0000;
  localparam logic [31:0] NEG5       = 32'hC0A0_0000;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;

  localparam logic [31:0] BP_075     = 32'h3F40_0000;
  localparam logic [31:0] BP_0921875 = 32'h3F6C_0000;

  localparam logic [31:0] OFF_SEG0   = 32'hBF00_0000;
  localparam logic [31:0] OFF_SEG1   = 32'hBF20_0000;
  localparam logic [31:0] OFF_SEG2   = 32'hBF58_0000;
  localparam logic [2:0]  K_SEG0     = 3'd2;
  localparam logic [2:0]  K_SEG1     = 3'd3;
  localparam logic [2:0]  K_SEG2     = 3'd5;

  typedef struct packed {
    logic [31:0] offset;
    logic [2:0]  k;
  } seg_t;

  // m is strictly positive here, so raw-bit ordering equals numeric ordering.
  function automatic seg_t seg_lookup(input logic [31:0] m);
    seg_t s;
    if (m < BP_075) begin
      s.offset = OFF_SEG0;
      s.k      = K_SEG0;
    end else if (m < BP_0921875) begin
      s.offset = OFF_SEG1;
      s.k      = K_SEG1;
    end else begin
      s.offset = OFF_SEG2;
      s.k      = K_SEG2;
    end
    return s;
  endfunction

endpackage

// File: rtl/float_add.sv
// Float32 adder, round-to-nearest-even, subnormals flushed to zero.
// Result is valid LAT-1 clocks after the operands; callers hold operands LAT cycles.
module float_add #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic [31:0]       big, sml, res;
  logic [7:0]        d_exp;
  logic [5:0]        sh, lz;
  logic [49:0]       m_big, m_sml, m_sh, n;
  logic [99:0]       wide;
  logic              sticky, rnd_up;
  logic [50:0]       raw;
  logic signed [9:0] e_n;
  logic [24:0]       m_rnd;

  always_comb begin
    if (a_i[30:0] >= b_i[30:0]) begin
      big = a_i;
      sml = b_i;
    end else begin
      big = b_i;
      sml = a_i;
    end
    m_big  = (big[30:23] == 8'd0) ? '0 : {1'b1, big[22:0], 26'd0};
    m_sml  = (sml[30:23] == 8'd0) ? '0 : {1'b1, sml[22:0], 26'd0};
    d_exp  = big[30:23] - sml[30:23];
    sh     = (d_exp > 8'd50) ? 6'd50 : d_exp[5:0];
    wide   = {m_sml, 50'd0} >> sh;
    m_sh   = wide[99:50];
    sticky = |wide[49:0];
    // Bits shifted out below the datapath still borrow one unit on subtraction.
    if (big[31] == sml[31]) raw = {1'b0, m_big} + {1'b0, m_sh};
    else                    raw = {1'b0, m_big} - {1'b0, m_sh} - {50'd0, sticky};
    lz  = '0;
    e_n = signed'({2'b00, big[30:23]});
    if (raw[50]) begin
      n      = raw[50:1];
      sticky = sticky | raw[0];
      e_n    = e_n + 10'sd1;
    end else begin
      for (int i = 0; i < 50; i++) begin
        if (raw[i]) lz = 6'(49 - i);
      end
      n   = raw[49:0] << lz;
      e_n = e_n - signed'({4'd0, lz});
    end
    rnd_up = n[25] & ((|n[24:0]) | sticky | n[26]);
    m_rnd  = {1'b0, n[49:26]} + {24'd0, rnd_up};
    if (m_rnd[24]) e_n = e_n + 10'sd1;
    res = '0;
    if (n[49] && e_n >= 10'sd255)
      res = {big[31], 8'hFF, 23'd0};
    else if (n[49] && e_n > 10'sd0)
      res = {big[31], e_n[7:0], (m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0])};
  end

  generate
    if (LAT <= 1) begin : g_comb
      assign sum_o = res;
    end else begin : g_pipe
      logic [31:0] pipe_q [LAT-1];
      always_ff @(posedge clk) begin
        pipe_q[0] <= res;
        for (int i = 1; i < LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign sum_o = pipe_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/sigmoid_inv_approx_scale.sv
// fp_pow2_scale: multiplies a non-negative float32 by 2^k through the exponent field,
// keeps zero as +0 and forces the sign bit to neg_i otherwise.
module fp_pow2_scale (
  input  logic [31:0] d_i,
  input  logic [2:0]  k_i,
  input  logic        neg_i,
  output logic [31:0] x_o
);

  always_comb begin
    x_o = '0;
    if (d_i[30:0] != 31'd0) x_o = {neg_i, d_i[30:23] + {5'd0, k_i}, d_i[22:0]};
  end

endmodule

// File: rtl/sigmoid_inv_approx.sv
// Piecewise-linear logit on float32 with one shared float_add and valid/ready on both sides.
// Optional SIGMOID_INV_SATCNT_EN adds sat_count, counting special-case (+-5, NaN) results.
module sigmoid_inv_approx
  import sigmoid_inv_approx_pkg::*;
#(
  parameter int ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x
`ifdef SIGMOID_INV_SATCNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(ADD_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] m_q, m_d;
  logic [31:0] dd_q, dd_d;
  logic        neg_q, neg_d;

  logic [31:0] add_a, add_b, add_sum, scaled;
  logic        y_nan;
  seg_t        seg;

  assign seg   = seg_lookup(m_q);
  assign y_nan = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);

  float_add #(.LAT(ADD_LAT)) u_add (
    .clk   (clk),
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  fp_pow2_scale u_scale (
    .d_i   (dd_q),
    .k_i   (seg.k),
    .neg_i (neg_q),
    .x_o   (scaled)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    dd_d    = dd_q;
    neg_d   = neg_q;
    add_a   = m_q;
    add_b   = seg.offset;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = y;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        state_d = DONE;
        if (y_nan)                                x_d = QNAN;
        else if (y_q[31] || y_q[30:0] == 31'd0)   x_d = NEG5;
        else if (y_q[30:0] >= ONE[30:0])          x_d = POS5;
        else if (y_q == HALF)                     x_d = '0;
        else if (y_q < HALF) begin
          neg_d   = 1'b1;
          state_d = REFLECT;
        end else begin
          neg_d   = 1'b0;
          m_d     = y_q;
          state_d = SUB;
        end
      end
      REFLECT: begin
        add_a = ONE;
        add_b = {~y_q[31], y_q[30:0]};
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          m_d     = add_sum;
          state_d = SUB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SUB: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          dd_d    = add_sum;
          state_d = SCALE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SCALE: begin
        x_d     = scaled;
        state_d = DONE;
      end
      DONE: begin
        // First DONE cycle raises out_valid; x is already final and stays put.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      x_q     <= x_d;
    end
  end

  always_ff @(posedge clk) begin
    y_q   <= y_d;
    m_q   <= m_d;
    dd_q  <= dd_d;
    neg_q <= neg_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign x         = x_q;

`ifdef SIGMOID_INV_SATCNT_EN
  logic        spec_q;
  logic [15:0] sat_cnt_q;

  // Special results are exactly the nonzero values decided in CLASSIFY.
  always_ff @(posedge clk) begin
    if (state_q == CLASSIFY) spec_q <= (state_d == DONE) && (x_d != 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst)
      sat_cnt_q <= '0;
    else if (state_q == DONE && vld_q && out_ready && spec_q && sat_cnt_q != 16'hFFFF)
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sigmoid_inv_approx.sv
// Scoreboard bench for sigmoid_inv_approx: real-valued reference model, queued expectations,
// independent monitor on the output handshake.
module tb_sigmoid_inv_approx;

  localparam int ADD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] y, x;
`ifdef SIGMOID_INV_SATCNT_EN
  logic [15:0] sat_count;
  logic [15:0] sat_base;
`endif

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;
  int     rdy_mode = 2;

  typedef struct {
    logic [31:0] yv;
    logic [31:0] xe;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t sb[$];

  sigmoid_inv_approx #(.ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x)
`ifdef SIGMOID_INV_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  function automatic real s2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] b;
    logic [23:0] m;
    int          e32;
    if (r == 0.0) return 32'h0;
    b   = $realtobits(r);
    e32 = int'(b[62:52]) - 1023 + 127;
    m   = {1'b0, b[51:29]};
    if (b[28] && (b[27:0] != 28'd0 || b[29])) m = m + 24'd1;
    if (m[23]) begin
      e32 = e32 + 1;
      m   = '0;
    end
    return {b[63], 8'(e32), m[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] yv, output int lat);
    real m, dv, xv, yr;
    int  k;
    bit  neg;
    lat = 2;
    if (yv[30:23] == 8'hFF && yv[22:0] != 23'd0) return 32'h7FC0_0000;
    if (yv[31] || yv[30:0] == 31'd0) return 32'hC0A0_0000;
    yr = s2r(yv);
    if (yr >= 1.0) return 32'h40A0_0000;
    if (yr == 0.5) return 32'h0;
    if (yr < 0.5) begin
      neg = 1'b1;
      m   = s2r(r2s(1.0 - yr));
      lat = 2 * ADD_LAT + 3;
    end else begin
      neg = 1'b0;
      m   = yr;
      lat = ADD_LAT + 3;
    end
    if (m < 0.75)          begin dv = m - 0.5;     k = 2; end
    else if (m < 0.921875) begin dv = m - 0.625;   k = 3; end
    else                   begin dv = m - 0.84375; k = 5; end
    xv = dv * real'(1 << k);
    if (xv == 0.0) return 32'h0;
    return r2s(neg ? -xv : xv);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] yv);
    exp_t e;
    int   t;
    e.yv = yv;
    e.xe = model(yv, e.lat);
    @(posedge clk); #1;
    in_valid = 1'b1;
    y        = yv;
    t        = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (in_ready) begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout y=%h in_ready=%b required=1", yv, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    bit   seen   = 1'b0;
    bit   orphan = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen   = 1'b0;
        orphan = 1'b0;
      end else begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            orphan = 1'b1;
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output x=%h required=no_output", x);
          end else begin
            e = sb[0];
            check($sformatf("latency y=%h", e.yv), 32'(cyc - e.acc), 32'(e.lat));
            check($sformatf("in_ready_busy y=%h", e.yv), {31'd0, in_ready}, 32'd0);
          end
        end
        if (out_valid && out_ready) begin
          if (!orphan && sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("result y=%h", e.yv), x, e.xe);
          end
          seen   = 1'b0;
          orphan = 1'b0;
        end
      end
    end
  end

  initial begin : main
    logic [31:0] dir_v [8] = '{32'h3F20_0000, 32'h3F60_0000, 32'h3F78_0000, 32'h3E80_0000,
                               32'h3F00_0000, 32'h3F40_0000, 32'h3F6C_0000, 32'h3EFF_FFFF};
    logic [31:0] spc_v [9] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h7F80_0000,
                               32'h7FC0_0001, 32'hBF00_0000, 32'h3F00_0000, 32'hFF80_0001,
                               32'h4000_0000};
    logic [31:0] yv;
    int          t;

    rst      = 1'b1;
    in_valid = 1'b0;
    y        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_x", x, 32'd0);
`ifdef SIGMOID_INV_SATCNT_EN
    check("reset_sat_count", {16'd0, sat_count}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (dir_v[i]) send(dir_v[i]);
    drain();

`ifdef SIGMOID_INV_SATCNT_EN
    sat_base = sat_count;
`endif
    send(32'h3F80_0000);
    send(32'hBF00_0000);
    send(32'h7FC0_0001);
    drain();
`ifdef SIGMOID_INV_SATCNT_EN
    check("sat_count_delta", {16'd0, sat_count - sat_base}, 32'd3);
`endif

    // Stall in DONE with a competing request that must not be taken.
    rdy_mode = 1;
    @(posedge clk);
    send(32'h3F20_0000);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      y        = 32'h3F60_0000;
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_x", x, 32'h3F00_0000);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 2;
    drain();

    // Abort while the adder is busy in SUB.
    @(posedge clk); #1;
    in_valid = 1'b1;
    y        = 32'h3F20_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_x", x, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_output", {31'd0, out_valid}, 32'd0);

    rdy_mode = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:          yv = spc_v[$urandom_range(0, 8)];
        1, 2, 3, 4: yv = {1'b0, 8'd126, 23'($urandom)};
        default:    yv = {1'b0, 8'($urandom_range(100, 125)), 23'($urandom)};
      endcase
      send(yv);
    end
    rdy_mode = 2;
    drain();
    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
